// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer with a one-word holding buffer.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// serial_out; a word offered while another is shifting waits in the buffer
// so consecutive words stream without an idle gap.
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             capture;
  logic             serial_nxt, valid_nxt, last_nxt;

  // Advance the shifter so the next bit to send sits at the output end.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  // Bit of a shifter word that is presented on serial_out.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  // Handshake and status decode depend on registered state only.
  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;
  assign busy     = (state == S_SHIFT) || hold_full;

  // State register plus the registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hold_full  <= 1'b0;
      serial_out <= IDLE_BIT;
      ser_valid  <= 1'b0;
      last_bit   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hold_full  <= hold_full_nxt;
      serial_out <= serial_nxt;
      ser_valid  <= valid_nxt;
      last_bit   <= last_nxt;
    end
  end

  // Data words carry no reset: the control state decides whether they are shown.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
    if (capture) hold_data <= in_data;
  end

  // Next-state logic: load, shift, buffer or reload at the end of a word.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hold_full_nxt = hold_full;
    shreg_nxt     = shreg;
    capture       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = '0;
          shreg_nxt = in_data;
        end
      end
      S_SHIFT: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (hold_full) begin
            shreg_nxt     = hold_data;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            shreg_nxt = in_data;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt   = cnt + 1'b1;
          shreg_nxt = shift_word(shreg);
          if (accept) begin
            capture       = 1'b1;
            hold_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered by the state register.
  always_comb begin
    valid_nxt  = (state_nxt == S_SHIFT);
    serial_nxt = valid_nxt ? head_bit(shreg_nxt) : IDLE_BIT;
    last_nxt   = valid_nxt && (cnt_nxt == LAST_CNT);
  end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the 11011 Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on serial_out, which drives the detector's signal input. A one-word holding buffer lets consecutive words stream with no idle gap. When no word is being shifted, serial_out holds a fixed idle level.

Parameters:
WIDTH, 8, bits per parallel word; legal range is 2 or more.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_BIT, 0, level driven on serial_out whenever ser_valid = 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous active-low reset.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a word this cycle.
serial_out  output  1  current serial bit; feeds the detector's signal input.
ser_valid  output  1  serial_out carries a data bit, not the idle level.
last_bit  output  1  high during the cycle the final bit of a word is on serial_out.
busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Reset (rst = 0, asynchronous, overrides everything):
  - shifter empty, holding buffer empty, bit counter = 0;
  - serial_out = IDLE_BIT, ser_valid = 0, last_bit = 0, busy = 0, in_ready = 1.
- Handshake:
  - a word is accepted on a rising edge where in_valid && in_ready;
  - in_ready = !hold_full, combinational from registered state only, with no path from in_valid;
  - in_data may change freely when not accepted.
- States: IDLE (shifter empty) and SHIFT (shifter loaded, counter 0..WIDTH-1).
- IDLE:
  - a word accepted at edge k loads straight into the shifter, counter = 0, state goes to SHIFT;
  - the first bit is on serial_out from edge k until edge k+1, so input-to-serial latency is 1 cycle.
  - A full holding buffer in IDLE cannot occur.
- SHIFT:
  - serial_out = current bit, ser_valid = 1, counter increments each edge;
  - last_bit = 1 when counter == WIDTH-1.
  - A word accepted while in SHIFT goes into the holding buffer (hold_full = 1, in_ready = 0 from the next cycle).
- Edge at which the last bit ends:
  - hold_full: shifter reloads from the buffer, counter = 0, hold_full clears, stay in SHIFT (no gap);
  - else, a word accepted on this same edge: load it directly into the shifter and stay in SHIFT (no gap);
  - else: go to IDLE; serial_out = IDLE_BIT and ser_valid = 0 from this edge.
- Bit order:
  - MSB_FIRST = 1: bit WIDTH-1 down to 0;
  - MSB_FIRST = 0: bit 0 up to WIDTH-1.
- busy = (state == SHIFT) || hold_full.
- All outputs are registered except in_ready and busy, which are decoded from registered state.
- Reset mid-word: the partial word is discarded and the buffered word is lost. After release, the block starts clean in IDLE with no residual bits.
- Throughput: sustained one bit per clock. At most one buffered word plus one in-flight word.

Test Plan:
1. WIDTH = 5, MSB_FIRST = 1, send 5'b11011 once -> serial_out = 1,1,0,1,1 on the 5 cycles after acceptance; ser_valid high exactly 5 cycles; last_bit high on the 5th; then serial_out = 0, busy = 0.
2. WIDTH = 5, in_valid held high with 5'b11011 then 5'b00110 -> 10 contiguous bits 1101100110 with no idle gap; in_ready drops for cycles 1..4 of the first word. Fed to the detector, it flags once.
3. WIDTH = 8, three words offered back-to-back (8'hA5, 8'h3C, 8'hFF) -> first loads immediately, second buffers (in_ready = 0), third is accepted only when in_ready returns; output is 24 contiguous bits in order.
4. WIDTH = 8, MSB_FIRST = 0, send 8'h01 -> serial_out = 1 then seven 0s.
5. Assert rst = 0 at bit 3 of a WIDTH = 8 word with a second word buffered -> outputs return to reset values immediately (asynchronously, not waiting for the edge); after release serial_out = IDLE_BIT, in_ready = 1, and no old bits appear.
6. IDLE_BIT = 1, no input for 20 cycles -> serial_out = 1, ser_valid = 0, busy = 0 throughout.
